// File: rtl/cdb_broadcast.sv
// Common Data Bus arbiter/broadcaster: picks one completed result per cycle by
// round-robin and drives the registered tag/value pair that stations snoop.
module cdb_broadcast #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [N_SRC-1:0]          Req,
  input  logic [N_SRC*DATA_W-1:0]   Result,
  input  logic                      Flush,
  output logic [N_SRC-1:0]          Grant,
  output logic                      CDB_Valid,
  output logic [TAG_W-1:0]          CDB_Tag,
  output logic [DATA_W-1:0]         CDB_Data,
  output logic [TAG_W-1:0]          Busy_Count
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  // Handshake: Req[i] is a level "valid" held with Result[i] stable until Grant[i]
  // ("ready") is seen high in the same cycle; the transfer completes at that edge.
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  idx;
  logic              found;
  logic              win;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N_SRC);
      if (!found && Req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Reset and Flush both squash the grant so no source believes it was accepted.
  assign win = found && !Reset && !Flush;

  always_comb begin
    Grant = '0;
    if (win) Grant[grant_idx] = 1'b1;
  end

  assign sel_data = Result[int'(grant_idx)*DATA_W +: DATA_W];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ptr        <= '0;
      CDB_Valid  <= 1'b0;
      CDB_Tag    <= '0;
      CDB_Data   <= '0;
      Busy_Count <= '0;
    end else begin
      CDB_Valid <= win;
      if (win) begin
        CDB_Tag  <= TAG_W'(grant_idx) + TAG_W'(1);
        CDB_Data <= sel_data;
        ptr      <= (grant_idx == PTR_W'(N_SRC - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (Flush)
        Busy_Count <= '0;
      else if ((|Req) && !win && (Busy_Count != {TAG_W{1'b1}}))
        Busy_Count <= Busy_Count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_broadcast.sv
// Bench for cdb_broadcast: directed scenarios with constant expectations plus a
// randomized run checked against a queue-based round-robin reference model.
module tb_cdb_broadcast;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [N-1:0]  req;
  logic [DW-1:0] res [N];
  logic [N*DW-1:0] result_flat;
  logic [N-1:0]  grant;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic [TW-1:0] busy_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  int            m_ptr;
  logic          m_valid;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;
  logic [TW-1:0] m_busy;
  logic [N-1:0]  g_obs, g_exp;
  logic          v_mid;
  logic [TW-1:0] t_mid;
  logic [TW+DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign result_flat[gi*DW +: DW] = res[gi];
  end

  cdb_broadcast #(.N_SRC(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .Clock(clk), .Reset(rst), .Req(req), .Result(result_flat), .Flush(flush),
    .Grant(grant), .CDB_Valid(cdb_valid), .CDB_Tag(cdb_tag), .CDB_Data(cdb_data),
    .Busy_Count(busy_count)
  );

  function automatic logic [N-1:0] ref_grant(input logic [N-1:0] r, input logic f, input logic rs);
    if (rs || f) return '0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (r[i]) return N'(1 << i);
    end
    return '0;
  endfunction

  // Drive one cycle: inputs after the edge, sample mid-cycle, advance model, wait past edge.
  task automatic step(input logic [N-1:0] r, input logic f, input logic rs);
    req = r; flush = f; rst = rs;
    #4;
    g_obs = grant;
    v_mid = cdb_valid;
    t_mid = cdb_tag;
    g_exp = ref_grant(r, f, rs);
    if (rs) begin
      m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_busy = '0;
    end else begin
      m_valid = (g_exp != '0);
      for (int i = 0; i < N; i++) begin
        if (g_exp[i]) begin
          m_tag  = TW'(i + 1);
          m_data = res[i];
          m_ptr  = (i + 1) % N;
          exp_q.push_back({m_tag, m_data});
        end
      end
      if (f) m_busy = '0;
      else if (r != '0 && g_exp == '0 && m_busy != '1) m_busy = m_busy + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(4'b1111, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b1);
    checks++; if (g_obs !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", g_obs); end
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", cdb_valid); end
    checks++; if (cdb_tag !== 3'd0) begin errors++; $display("FAIL reset_tag got %0d exp 0", cdb_tag); end
    checks++; if (cdb_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", cdb_data); end
    checks++; if (busy_count !== 3'd0) begin errors++; $display("FAIL reset_busy got %0d exp 0", busy_count); end
    res[0] = 16'h1234;
    step(4'b1111, 1'b0, 1'b0);
    checks++; if (g_obs !== 4'b0001) begin errors++; $display("FAIL first_grant got %b exp 0001", g_obs); end
    checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd1 || cdb_data !== 16'h1234) begin
      errors++; $display("FAIL first_bcast got v=%b t=%0d d=%h exp v=1 t=1 d=1234", cdb_valid, cdb_tag, cdb_data); end
  endtask

  task automatic test_single();
    step(4'b0000, 1'b0, 1'b0);
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", cdb_valid); end
    res[2] = 16'h00A5;
    step(4'b0100, 1'b0, 1'b0);
    checks++; if (g_obs !== 4'b0100) begin errors++; $display("FAIL single_grant got %b exp 0100", g_obs); end
    checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd3 || cdb_data !== 16'h00A5) begin
      errors++; $display("FAIL single_bcast got v=%b t=%0d d=%h exp v=1 t=3 d=00a5", cdb_valid, cdb_tag, cdb_data); end
    step(4'b0000, 1'b0, 1'b0);
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %b exp 0", cdb_valid); end
  endtask

  task automatic test_round_robin();
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) res[i] = 16'h1000 + 16'(i);
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b0, 1'b0);
      checks++;
      if (cdb_valid !== 1'b1 || cdb_tag !== TW'((k % N) + 1) || cdb_data !== 16'h1000 + 16'(k % N)) begin
        errors++;
        $display("FAIL rr_step%0d got v=%b t=%0d d=%h exp v=1 t=%0d d=%h", k, cdb_valid, cdb_tag,
                 cdb_data, (k % N) + 1, 16'h1000 + 16'(k % N));
      end
    end
  endtask

  task automatic test_wrap_skip();
    step(4'b0100, 1'b0, 1'b0);
    checks++; if (cdb_tag !== 3'd3) begin errors++; $display("FAIL wrap_setup got %0d exp 3", cdb_tag); end
    step(4'b0011, 1'b0, 1'b0);
    checks++; if (g_obs !== 4'b0001 || cdb_tag !== 3'd1) begin
      errors++; $display("FAIL wrap_first got g=%b t=%0d exp g=0001 t=1", g_obs, cdb_tag); end
    step(4'b0011, 1'b0, 1'b0);
    checks++; if (g_obs !== 4'b0010 || cdb_tag !== 3'd2) begin
      errors++; $display("FAIL wrap_second got g=%b t=%0d exp g=0010 t=2", g_obs, cdb_tag); end
  endtask

  task automatic test_flush();
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    checks++; if (g_obs !== 4'b0000) begin errors++; $display("FAIL flush_grant got %b exp 0000", g_obs); end
    checks++; if (v_mid !== 1'b1 || t_mid !== 3'd4) begin
      errors++; $display("FAIL flush_visible got v=%b t=%0d exp v=1 t=4", v_mid, t_mid); end
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", cdb_valid); end
    checks++; if (busy_count !== 3'd0) begin errors++; $display("FAIL flush_busy got %0d exp 0", busy_count); end
    step(4'b1010, 1'b0, 1'b0);
    checks++; if (g_obs !== 4'b0010 || cdb_tag !== 3'd2 || cdb_valid !== 1'b1) begin
      errors++; $display("FAIL flush_resume got g=%b t=%0d v=%b exp g=0010 t=2 v=1", g_obs, cdb_tag, cdb_valid); end
  endtask

  task automatic test_reset_mid();
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b1);
    checks++; if (g_obs !== 4'b0000) begin errors++; $display("FAIL midrst_grant got %b exp 0000", g_obs); end
    checks++; if (cdb_valid !== 1'b0 || cdb_tag !== 3'd0) begin
      errors++; $display("FAIL midrst_bus got v=%b t=%0d exp v=0 t=0", cdb_valid, cdb_tag); end
    step(4'b1111, 1'b0, 1'b0);
    checks++; if (g_obs !== 4'b0001 || cdb_tag !== 3'd1) begin
      errors++; $display("FAIL midrst_next got g=%b t=%0d exp g=0001 t=1", g_obs, cdb_tag); end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic         f;
    logic [TW+DW-1:0] got, want;
    int           wait_cnt [N];
    step(4'b0000, 1'b0, 1'b0);
    exp_q.delete();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    r = '0;
    for (int c = 0; c < 300; c++) begin
      // a pending requester keeps Req and Result until granted
      for (int i = 0; i < N; i++) begin
        if (!r[i]) begin
          r[i] = ($urandom_range(0, 2) != 0);
          res[i] = 16'($urandom);
        end
      end
      f = ($urandom_range(0, 7) == 0);
      step(r, f, 1'b0);
      checks++; if (g_obs !== g_exp) begin errors++; $display("FAIL rnd_grant c=%0d got %b exp %b", c, g_obs, g_exp); end
      checks++; if (cdb_valid !== m_valid || busy_count !== m_busy) begin
        errors++; $display("FAIL rnd_state c=%0d got v=%b b=%0d exp v=%b b=%0d", c, cdb_valid, busy_count, m_valid, m_busy); end
      if (cdb_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_bcast c=%0d got t=%0d d=%h exp none", c, cdb_tag, cdb_data);
        end else begin
          want = exp_q.pop_front();
          got  = {cdb_tag, cdb_data};
          if (got !== want) begin errors++; $display("FAIL rnd_bcast c=%0d got %h exp %h", c, got, want); end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (g_exp[i]) begin
          checks++;
          if (wait_cnt[i] >= N) begin errors++; $display("FAIL rnd_fair src=%0d got wait %0d exp <%0d", i, wait_cnt[i], N); end
          wait_cnt[i] = 0;
          r[i] = 1'b0;
        end else if (r[i] && !f) begin
          wait_cnt[i]++;
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d left exp 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req = '0;
    for (int i = 0; i < N; i++) res[i] = '0;
    m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_busy = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
